// File: rtl/trap_sequencer.sv
// Trap/uret sequencer: accepts one exception, uret or interrupt in IDLE and walks it through CSR writes and a PC redirect.
// Optional feature: define TRAP_VECTORED_MODE_EN to enable vectored interrupt dispatch when utvec[1:0]==2'b01.
module trap_sequencer #(
  parameter int unsigned UTVEC_ALIGN = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iExcReq,
  input  logic [31:0] iExcCause,
  input  logic [31:0] iExcPC,
  input  logic [31:0] iExcTval,
  input  logic        iURET,
  input  logic [2:0]  iIntPend,
  input  logic [31:0] iCurPC,
  input  logic [31:0] iUSTATUS,
  input  logic [31:0] iUIE,
  input  logic [31:0] iUTVEC,
  input  logic [31:0] iUEPC,
  output logic        oRegWriteSimu,
  output logic [31:0] oWriteDataUEPC,
  output logic [31:0] oWriteDataUCAUSE,
  output logic [31:0] oWriteDataUTVAL,
  output logic        oCSRWrite,
  output logic [11:0] oCSRWriteAddr,
  output logic [31:0] oCSRWriteData,
  output logic        oPCLoad,
  output logic [31:0] oTrapPC,
  output logic        oAck,
  output logic        oStall,
  output logic        oBusy
);

  localparam int unsigned XW = 32;
  localparam int unsigned AW = 12;
  localparam logic [AW-1:0] USTATUS_ADDR = AW'(0);
  localparam logic [XW-1:0] ALIGN_MASK   = ~((XW'(1) << UTVEC_ALIGN) - XW'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_STATUS, S_VECTOR, S_RESTORE, S_RETURN
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] cause_q, epc_q, tval_q;
  logic          hold_q;
  logic          can_accept, int_ext, int_sw, int_tmr, int_any;
  logic          take_exc, take_uret, take_int, accept;
  logic [3:0]    int_code;
  logic [XW-1:0] vector_pc;
`ifdef TRAP_VECTORED_MODE_EN
  logic          is_int_q;
`endif

  logic unused_uie;
  assign unused_uie = ^{iUIE[31:9], iUIE[7:5], iUIE[3:1]};

  // Request arbitration: exception > uret > external > software > timer interrupt.
  always_comb begin
    can_accept = (state == S_IDLE) && !hold_q && !iRST;
    int_ext    = iUSTATUS[0] && iIntPend[2] && iUIE[8];
    int_sw     = iUSTATUS[0] && iIntPend[0] && iUIE[0];
    int_tmr    = iUSTATUS[0] && iIntPend[1] && iUIE[4];
    int_any    = int_ext || int_sw || int_tmr;
    int_code   = int_ext ? 4'd8 : (int_sw ? 4'd0 : 4'd4);
    take_exc   = can_accept && iExcReq;
    take_uret  = can_accept && !iExcReq && iURET;
    take_int   = can_accept && !iExcReq && !iURET && int_any;
    accept     = take_exc || take_uret || take_int;
  end

  // Trap target: direct base, or base + 4*code for vectored interrupts.
  always_comb begin
    vector_pc = iUTVEC & ALIGN_MASK;
`ifdef TRAP_VECTORED_MODE_EN
    if (is_int_q && (iUTVEC[1:0] == 2'b01))
      vector_pc = {iUTVEC[31:2], 2'b00} + (XW'(cause_q[3:0]) << 2);
`endif
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= S_IDLE;
      hold_q  <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
`ifdef TRAP_VECTORED_MODE_EN
      is_int_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      // The first IDLE cycle after a sequence never accepts.
      hold_q <= (state == S_VECTOR) || (state == S_RETURN);
      if (take_exc) begin
        cause_q <= iExcCause;
        epc_q   <= iExcPC;
        tval_q  <= iExcTval;
`ifdef TRAP_VECTORED_MODE_EN
        is_int_q <= 1'b0;
`endif
      end else if (take_int) begin
        cause_q <= {1'b1, 27'b0, int_code};
        epc_q   <= iCurPC;
        tval_q  <= '0;
`ifdef TRAP_VECTORED_MODE_EN
        is_int_q <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_n          = state;
    oRegWriteSimu    = 1'b0;
    oWriteDataUEPC   = '0;
    oWriteDataUCAUSE = '0;
    oWriteDataUTVAL  = '0;
    oCSRWrite        = 1'b0;
    oCSRWriteAddr    = '0;
    oCSRWriteData    = '0;
    oPCLoad          = 1'b0;
    oTrapPC          = '0;
    oAck             = 1'b0;
    oBusy            = (state != S_IDLE);
    oStall           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          oAck    = 1'b1;
          oStall  = 1'b1;
          state_n = take_uret ? S_RESTORE : S_SAVE;
        end
      end
      S_SAVE: begin
        oRegWriteSimu    = 1'b1;
        oWriteDataUEPC   = epc_q;
        oWriteDataUCAUSE = cause_q;
        oWriteDataUTVAL  = tval_q;
        state_n          = S_STATUS;
      end
      S_STATUS: begin
        oCSRWrite        = 1'b1;
        oCSRWriteAddr    = USTATUS_ADDR;
        oCSRWriteData    = iUSTATUS;
        oCSRWriteData[4] = iUSTATUS[0];
        oCSRWriteData[0] = 1'b0;
        state_n          = S_VECTOR;
      end
      S_VECTOR: begin
        oPCLoad = 1'b1;
        oTrapPC = vector_pc;
        state_n = S_IDLE;
      end
      S_RESTORE: begin
        oCSRWrite        = 1'b1;
        oCSRWriteAddr    = USTATUS_ADDR;
        oCSRWriteData    = iUSTATUS;
        oCSRWriteData[0] = iUSTATUS[4];
        oCSRWriteData[4] = 1'b1;
        state_n          = S_RETURN;
      end
      S_RETURN: begin
        oPCLoad = 1'b1;
        oTrapPC = iUEPC;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random requests checked cycle-by-cycle against a queue-based model.
module tb_trap_sequencer;

  localparam int ALIGN = 2;
  localparam int K_SAVE = 0, K_STATUS = 1, K_VECTOR = 2, K_RESTORE = 3, K_RETURN = 4;

  typedef struct packed {
    logic        regw;
    logic [31:0] uepc;
    logic [31:0] ucause;
    logic [31:0] utval;
    logic        csrw;
    logic [11:0] addr;
    logic [31:0] csrdata;
    logic        pcload;
    logic [31:0] trappc;
    logic        ack;
    logic        stall;
    logic        busy;
  } out_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        exc = 1'b0, uret = 1'b0;
  logic [31:0] exc_cause = '0, exc_pc = '0, exc_tval = '0;
  logic [2:0]  intpend = '0;
  logic [31:0] curpc = '0, ustatus = '0, uie = '0, utvec = '0, uepc = '0;

  logic        regw, csrw, pcload, ack, stall, busy;
  logic [31:0] wd_uepc, wd_ucause, wd_utval, csrdata, trappc;
  logic [11:0] csraddr;

  int   n_tests = 0, n_fail = 0;
  int   kq[$];
  bit   blocked = 0;
  logic [31:0] m_cause = '0, m_epc = '0, m_tval = '0;
  bit   m_int = 0;
  out_t g;

  trap_sequencer #(.UTVEC_ALIGN(ALIGN)) dut (
    .iCLK(clk), .iRST(rst), .iExcReq(exc), .iExcCause(exc_cause), .iExcPC(exc_pc),
    .iExcTval(exc_tval), .iURET(uret), .iIntPend(intpend), .iCurPC(curpc),
    .iUSTATUS(ustatus), .iUIE(uie), .iUTVEC(utvec), .iUEPC(uepc),
    .oRegWriteSimu(regw), .oWriteDataUEPC(wd_uepc), .oWriteDataUCAUSE(wd_ucause),
    .oWriteDataUTVAL(wd_utval), .oCSRWrite(csrw), .oCSRWriteAddr(csraddr),
    .oCSRWriteData(csrdata), .oPCLoad(pcload), .oTrapPC(trappc),
    .oAck(ack), .oStall(stall), .oBusy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_vec(input logic [31:0] tv, input bit is_int, input logic [31:0] cause);
    logic [31:0] base;
    base = (tv >> ALIGN) << ALIGN;
`ifdef TRAP_VECTORED_MODE_EN
    if (is_int && tv[1:0] == 2'b01) base = ((tv >> 2) << 2) + 4 * {28'b0, cause[3:0]};
`endif
    return base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: model predicts this cycle's outputs from the current inputs, compared at negedge.
  task automatic tick(input string tag);
    out_t e;
    bit   nb;
    int   k;
    int   src[3] = '{2, 0, 1};
    int   ebit[3] = '{8, 0, 4};
    int   code[3] = '{8, 0, 4};
    @(negedge clk);
    e  = '0;
    nb = 0;
    if (rst) begin
      kq.delete();
    end else if (kq.size() != 0) begin
      k = kq.pop_front();
      e.stall = 1; e.busy = 1;
      case (k)
        K_SAVE:    begin e.regw = 1; e.uepc = m_epc; e.ucause = m_cause; e.utval = m_tval; end
        K_STATUS:  begin e.csrw = 1; e.csrdata = (ustatus & ~32'h11) | (ustatus[0] ? 32'h10 : 32'h0); end
        K_VECTOR:  begin e.pcload = 1; e.trappc = exp_vec(utvec, m_int, m_cause); end
        K_RESTORE: begin e.csrw = 1; e.csrdata = (ustatus & ~32'h1) | 32'h10 | (ustatus[4] ? 32'h1 : 32'h0); end
        default:   begin e.pcload = 1; e.trappc = uepc; end
      endcase
      nb = (kq.size() == 0);
    end else if (!blocked) begin
      if (exc) begin
        m_cause = exc_cause; m_epc = exc_pc; m_tval = exc_tval; m_int = 0;
        kq = '{K_SAVE, K_STATUS, K_VECTOR};
      end else if (uret) begin
        kq = '{K_RESTORE, K_RETURN};
      end else if (ustatus[0]) begin
        for (int i = 0; i < 3; i++) begin
          if (kq.size() == 0 && intpend[src[i]] && uie[ebit[i]]) begin
            m_cause = 32'h8000_0000 | code[i]; m_epc = curpc; m_tval = 0; m_int = 1;
            kq = '{K_SAVE, K_STATUS, K_VECTOR};
          end
        end
      end
      if (kq.size() != 0) begin e.ack = 1; e.stall = 1; end
    end
    blocked = nb;
    g = '{regw, wd_uepc, wd_ucause, wd_utval, csrw, csraddr, csrdata, pcload, trappc, ack, stall, busy};
    n_tests++;
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, g, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acked, want;
    tick("reset");
    chk("reset_busy", 32'(busy), 0);
    rst = 0;

    // Exception with direct vector.
    ustatus = 32'h1; utvec = 32'h0040_0100;
    exc = 1; exc_cause = 2; exc_pc = 32'h0040_0010; exc_tval = 32'hDEAD;
    tick("exc_accept"); chk("exc_ack", 32'(g.ack), 1);
    exc = 0;
    tick("exc_save");
    chk("exc_uepc", g.uepc, 32'h0040_0010); chk("exc_ucause", g.ucause, 2); chk("exc_utval", g.utval, 32'hDEAD);
    tick("exc_status"); chk("exc_status_data", g.csrdata, 32'h10);
    tick("exc_vector"); chk("exc_trappc", g.trappc, 32'h0040_0100);

    // All interrupts pending: external wins.
    intpend = 3'b111; uie = 32'h111; curpc = 32'h0040_0020;
    tick("int_blocked"); chk("int_blocked_ack", 32'(g.ack), 0);
    tick("int_accept");
    intpend = 0;
    tick("int_save");
    chk("int_ucause", g.ucause, 32'h8000_0008); chk("int_uepc", g.uepc, 32'h0040_0020); chk("int_utval", g.utval, 0);
    tick("int_status"); tick("int_vector"); tick("int_gap");

    // Interrupts globally disabled, then exception beats uret.
    ustatus = 0; intpend = 3'b111;
    repeat (3) tick("int_disabled");
    chk("dis_ack", 32'(g.ack), 0); chk("dis_busy", 32'(g.busy), 0);
    intpend = 0; exc = 1; uret = 1; exc_cause = 5; exc_pc = 32'h0040_0030; exc_tval = 32'h7;
    tick("prio_accept"); exc = 0; uret = 0;
    tick("prio_save"); chk("prio_regw", 32'(g.regw), 1); chk("prio_csrw", 32'(g.csrw), 0);
    tick("prio_status"); tick("prio_vector"); tick("prio_gap");

    // uret: three-cycle stall.
    ustatus = 32'h10; uepc = 32'h0040_0050; uret = 1;
    tick("uret_accept"); chk("uret_stall0", 32'(g.stall), 1); uret = 0;
    tick("uret_restore"); chk("uret_data", g.csrdata, 32'h11); chk("uret_stall1", 32'(g.stall), 1);
    tick("uret_return"); chk("uret_pc", g.trappc, 32'h0040_0050); chk("uret_stall2", 32'(g.stall), 1);
    tick("uret_done"); chk("uret_stall3", 32'(g.stall), 0);

    // Reset in STATUS abandons the sequence.
    ustatus = 32'h1; exc = 1;
    tick("rst_accept"); exc = 0;
    tick("rst_save");
    rst = 1;
    tick("rst_in_status"); chk("rst_outputs", 32'(|g), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin tick("rst_after"); chk("rst_no_pcload", 32'(g.pcload), 0); end

`ifdef TRAP_VECTORED_MODE_EN
    utvec = 32'h0040_0101; intpend = 3'b010; uie = 32'h10; ustatus = 32'h1;
    tick("vec_accept"); intpend = 0;
    tick("vec_save"); tick("vec_status");
    tick("vec_vector"); chk("vec_trappc", g.trappc, 32'h0040_0110);
    tick("vec_gap");
`endif

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      exc = ($urandom_range(0, 3) == 0); uret = ($urandom_range(0, 3) == 0);
      exc_cause = $urandom; exc_pc = $urandom; exc_tval = $urandom;
      intpend = 3'($urandom); curpc = $urandom; uepc = $urandom;
      ustatus = $urandom; uie = $urandom; utvec = $urandom;
      want = exc || uret;
      acked = 0;
      for (int c = 0; c < 10 && !acked; c++) begin
        rst = ($urandom_range(0, 40) == 0);
        tick("rand");
        rst = 0;
        if (g.ack) begin acked = 1; exc = 0; uret = 0; intpend = 0; end
      end
      if (want) chk("rand_ack_bound", 32'(acked), 1);
      exc = 0; uret = 0; intpend = 0;
      repeat (5) tick("rand_drain");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
